aes_input_loader: RTL

Word-serial front end for the `AES` core. It accepts 32-bit key and plaintext words over a valid/ready stream and assembles them into the core's 128-bit `key` and `plain_text` buses. It fires a one-cycle `input_valid` launch, then holds off new input until the core's `output_valid` completion. The last loaded key is retained, so successive blocks need only four plaintext words.

---
 rtl/aes_input_loader_if.sv | 14 +
 rtl/aes_input_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/aes_input_loader_if.sv
// Word stream carrying 32-bit key/plaintext words into the AES input loader.
//   s_data   : input word
//   s_valid  : s_data/s_is_key are valid
//   s_is_key : 1 = key word, 0 = plaintext word
//   s_ready  : word accepted on a cycle where s_valid && s_ready
interface aes_input_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_is_key;
  logic        s_ready;

  modport master (output s_data, output s_valid, output s_is_key, input s_ready);
  modport slave  (input s_data, input s_valid, input s_is_key, output s_ready);
endinterface

// File: rtl/aes_input_loader.sv
// Word-serial front end for the AES core: assembles four 32-bit words into the
// 128-bit key / plain_text buses (big-endian), fires a one-cycle input_valid
// launch and holds off the stream until output_valid or the watchdog expires.
// The last committed key is retained across blocks.
//   clk, rst      : clock, synchronous active-high reset
//   s             : word stream (slave side)
//   output_valid  : completion pulse from the core (honoured in WAIT only)
//   plain_text    : committed plaintext block
//   key           : committed key
//   input_valid   : one-cycle launch pulse
//   key_loaded    : a full key has been committed since reset
//   busy          : launch or wait in progress
//   timeout_err   : sticky watchdog flag
module aes_input_loader #(
  parameter int unsigned LAT_MAX = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_input_loader_if.slave    s,
  input  logic                 output_valid,
  output logic [127:0]         plain_text,
  output logic [127:0]         key,
  output logic                 input_valid,
  output logic                 key_loaded,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STAGE_W = 3 * WORD_W;
  localparam int unsigned WCNT_W  = 16;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_PEND,
    ST_LAUNCH,
    ST_WAIT
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [1:0]          kcnt;
  logic [1:0]          pcnt;
  logic [STAGE_W-1:0]  kstage;
  logic [STAGE_W-1:0]  pstage;
  logic [WCNT_W-1:0]   wcnt;

  logic ready_c;
  logic key_acc_c;
  logic pt_acc_c;
  logic key_commit_c;
  logic pt_commit_c;
  logic timeout_hit_c;

  assign s.s_ready = ready_c;

  // Next-state, stream ready and accept/commit decode
  always_comb begin
    state_next    = state;
    ready_c       = 1'b0;
    timeout_hit_c = 1'b0;

    case (state)
      ST_COLLECT: ready_c = 1'b1;
      ST_PEND:    ready_c = s.s_is_key;   // only key words may enter while a block is parked
      default:    ready_c = 1'b0;
    endcase
    if (rst) ready_c = 1'b0;

    key_acc_c    = s.s_valid && ready_c && s.s_is_key;
    pt_acc_c     = s.s_valid && ready_c && !s.s_is_key;
    key_commit_c = key_acc_c && (kcnt == 2'd3);
    pt_commit_c  = pt_acc_c && (pcnt == 2'd3);

    case (state)
      ST_COLLECT: if (pt_commit_c) state_next = key_loaded ? ST_LAUNCH : ST_PEND;
      ST_PEND:    if (key_commit_c) state_next = ST_LAUNCH;
      ST_LAUNCH:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (output_valid) begin
          state_next = ST_COLLECT;
        end else if (wcnt == WCNT_W'(LAT_MAX)) begin
          state_next    = ST_COLLECT;
          timeout_hit_c = 1'b1;
        end
      end
      default:    state_next = ST_COLLECT;
    endcase
  end

  // State register, staging datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_COLLECT;
      kcnt        <= 2'd0;
      pcnt        <= 2'd0;
      kstage      <= '0;
      pstage      <= '0;
      wcnt        <= '0;
      key         <= '0;
      plain_text  <= '0;
      input_valid <= 1'b0;
      key_loaded  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      input_valid <= (state_next == ST_LAUNCH);
      busy        <= (state_next == ST_LAUNCH) || (state_next == ST_WAIT);

      // Staging shifts left so the first word ends up in the top 32 bits
      if (key_acc_c) begin
        kcnt   <= kcnt + 2'd1;
        kstage <= {kstage[STAGE_W-WORD_W-1:0], s.s_data};
        if (key_commit_c) begin
          key        <= {kstage, s.s_data};
          key_loaded <= 1'b1;
        end
      end
      if (pt_acc_c) begin
        pcnt   <= pcnt + 2'd1;
        pstage <= {pstage[STAGE_W-WORD_W-1:0], s.s_data};
        if (pt_commit_c) plain_text <= {pstage, s.s_data};
      end

      // Watchdog reads 1 on the first WAIT cycle
      if (state_next == ST_WAIT) begin
        wcnt <= (state == ST_LAUNCH) ? WCNT_W'(1) : wcnt + WCNT_W'(1);
      end else begin
        wcnt <= '0;
      end

      if (timeout_hit_c) timeout_err <= 1'b1;
    end
  end

endmodule
